// File: rtl/reservation_station_if.sv
// Decoder/CDB/ALU-facing bundle of the reservation station.
// The master side drives issue and CDB traffic; the slave side is the RS.
interface reservation_station_if #(
    parameter int TAG_W = 5
);
    logic             if_rs_idle;
    logic             if_issue_rs;
    logic [TAG_W-1:0] dest_rs;
    logic [5:0]       op_type_to_rs;
    logic [TAG_W-1:0] tag_rs1_to_rs;
    logic [TAG_W-1:0] tag_rs2_to_rs;
    logic [31:0]      data_rs1_to_rs;
    logic [31:0]      data_rs2_to_rs;
    logic [31:0]      imm_to_rs;
    logic [31:0]      pc_to_rs;

    logic             alu_cdb_valid;
    logic [TAG_W-1:0] alu_cdb_tag;
    logic [31:0]      alu_cdb_data;
    logic             lsb_cdb_valid;
    logic [TAG_W-1:0] lsb_cdb_tag;
    logic [31:0]      lsb_cdb_data;

    logic             ex_valid;
    logic [5:0]       ex_op;
    logic [31:0]      ex_v1;
    logic [31:0]      ex_v2;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_pc;
    logic [TAG_W-1:0] ex_dest;

    modport master (
        input  if_rs_idle, ex_valid, ex_op, ex_v1, ex_v2, ex_imm, ex_pc, ex_dest,
        output if_issue_rs, dest_rs, op_type_to_rs, tag_rs1_to_rs, tag_rs2_to_rs,
               data_rs1_to_rs, data_rs2_to_rs, imm_to_rs, pc_to_rs,
               alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data
    );

    modport slave (
        output if_rs_idle, ex_valid, ex_op, ex_v1, ex_v2, ex_imm, ex_pc, ex_dest,
        input  if_issue_rs, dest_rs, op_type_to_rs, tag_rs1_to_rs, tag_rs2_to_rs,
               data_rs1_to_rs, data_rs2_to_rs, imm_to_rs, pc_to_rs,
               alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds issued ops until both operands resolve via the
// ALU/LSB CDBs, then dispatches the lowest-index ready entry to the ALU.
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    reservation_station_if.slave rs
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] q;
        logic [31:0]      v;
    } src_t;

    logic [RS_SIZE-1:0] r_busy;
    logic [5:0]         r_op   [RS_SIZE];
    logic [TAG_W-1:0]   r_q1   [RS_SIZE];
    logic [TAG_W-1:0]   r_q2   [RS_SIZE];
    logic [TAG_W-1:0]   r_dest [RS_SIZE];
    logic [31:0]        r_v1   [RS_SIZE];
    logic [31:0]        r_v2   [RS_SIZE];
    logic [31:0]        r_imm  [RS_SIZE];
    logic [31:0]        r_pc   [RS_SIZE];

    logic               r_ex_valid;
    logic [5:0]         r_ex_op;
    logic [31:0]        r_ex_v1, r_ex_v2, r_ex_imm, r_ex_pc;
    logic [TAG_W-1:0]   r_ex_dest;

    logic               w_alu_valid, w_lsb_valid;
    logic [TAG_W-1:0]   w_alu_tag, w_lsb_tag;
    logic [31:0]        w_alu_data, w_lsb_data;
    logic               w_any_ready, w_any_free, w_issue;
    logic [IDX_W-1:0]   w_disp_idx, w_free_idx;
    src_t               w_iss1, w_iss2;
    src_t               w_wake1 [RS_SIZE];
    src_t               w_wake2 [RS_SIZE];

    assign w_alu_valid = rs.alu_cdb_valid;
    assign w_alu_tag   = rs.alu_cdb_tag;
    assign w_alu_data  = rs.alu_cdb_data;
    assign w_lsb_valid = rs.lsb_cdb_valid;
    assign w_lsb_tag   = rs.lsb_cdb_tag;
    assign w_lsb_data  = rs.lsb_cdb_data;

    // Tag 0 means "value present", so it never matches a broadcast.
    function automatic src_t snoop(input logic [TAG_W-1:0] q, input logic [31:0] v);
        src_t s;
        s.q = q;
        s.v = v;
        if (q != '0) begin
            if (w_alu_valid && q == w_alu_tag) begin
                s.q = '0;
                s.v = w_alu_data;
            end else if (w_lsb_valid && q == w_lsb_tag) begin
                s.q = '0;
                s.v = w_lsb_data;
            end
        end
        return s;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_any_ready = 1'b0;
        w_any_free  = 1'b0;
        w_disp_idx  = '0;
        w_free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (r_busy[i] && r_q1[i] == '0 && r_q2[i] == '0) begin
                w_any_ready = 1'b1;
                w_disp_idx  = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_iss1 = snoop(rs.tag_rs1_to_rs, rs.data_rs1_to_rs);
        w_iss2 = snoop(rs.tag_rs2_to_rs, rs.data_rs2_to_rs);
        for (int i = 0; i < RS_SIZE; i++) begin
            w_wake1[i] = snoop(r_q1[i], r_v1[i]);
            w_wake2[i] = snoop(r_q2[i], r_v2[i]);
        end
    end

    assign w_issue = rs.if_issue_rs && rdy_in && !clr_in &&
                     rs.op_type_to_rs != 6'd0 && w_any_free;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy     <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_v1    <= '0;
            r_ex_v2    <= '0;
            r_ex_imm   <= '0;
            r_ex_pc    <= '0;
            r_ex_dest  <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                r_busy     <= '0;
                r_ex_valid <= 1'b0;
            end else begin
                r_ex_valid <= w_any_ready;
                if (w_any_ready) begin
                    r_ex_op              <= r_op[w_disp_idx];
                    r_ex_v1              <= r_v1[w_disp_idx];
                    r_ex_v2              <= r_v2[w_disp_idx];
                    r_ex_imm             <= r_imm[w_disp_idx];
                    r_ex_pc              <= r_pc[w_disp_idx];
                    r_ex_dest            <= r_dest[w_disp_idx];
                    r_busy[w_disp_idx]   <= 1'b0;
                end
                // The issue slot is free and the dispatch slot is busy, so they never collide.
                if (w_issue)
                    r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    // NOTE: entry payload is not reset; it is meaningless while its busy bit is clear.
    for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
        always_ff @(posedge clk_in) begin
            if (rdy_in && !clr_in) begin
                if (w_issue && w_free_idx == IDX_W'(g)) begin
                    r_op[g]   <= rs.op_type_to_rs;
                    r_dest[g] <= rs.dest_rs;
                    r_imm[g]  <= rs.imm_to_rs;
                    r_pc[g]   <= rs.pc_to_rs;
                    r_q1[g]   <= w_iss1.q;
                    r_v1[g]   <= w_iss1.v;
                    r_q2[g]   <= w_iss2.q;
                    r_v2[g]   <= w_iss2.v;
                end else if (r_busy[g]) begin
                    r_q1[g] <= w_wake1[g].q;
                    r_v1[g] <= w_wake1[g].v;
                    r_q2[g] <= w_wake2[g].q;
                    r_v2[g] <= w_wake2[g].v;
                end
            end
        end
    end

    assign rs.if_rs_idle = w_any_free;
    assign rs.ex_valid   = r_ex_valid;
    assign rs.ex_op      = r_ex_op;
    assign rs.ex_v1      = r_ex_v1;
    assign rs.ex_v2      = r_ex_v2;
    assign rs.ex_imm     = r_ex_imm;
    assign rs.ex_pc      = r_ex_pc;
    assign rs.ex_dest    = r_ex_dest;
endmodule
